// File: rtl/lif_scheduler_if.sv
// Bus bundle for lif_scheduler: sweep request, currents, configuration, readout and sweep results.
// tick is taken only while busy is low; a tick seen while busy is high is dropped, never queued.
interface lif_scheduler_if #(
   parameter int N_NEURONS = 4,
   parameter int AW        = 2
);
   logic                   tick;
   logic [4*N_NEURONS-1:0] current_in;
   logic                   cfg_we;
   logic [AW-1:0]          cfg_addr;
   logic [3:0]             cfg_threshold;
   logic [1:0]             leak_shift;
   logic [2:0]             refrac_cfg;
   logic [AW-1:0]          rd_addr;
   logic [3:0]             rd_state;
   logic                   busy;
   logic                   done;
   logic [N_NEURONS-1:0]   spike_vec;
   logic [7:0]             spike_count;
   logic [1:0]             state_dbg;

   modport master (
      output tick, current_in, cfg_we, cfg_addr, cfg_threshold,
             leak_shift, refrac_cfg, rd_addr,
      input  rd_state, busy, done, spike_vec, spike_count, state_dbg
   );

   modport slave (
      input  tick, current_in, cfg_we, cfg_addr, cfg_threshold,
             leak_shift, refrac_cfg, rd_addr,
      output rd_state, busy, done, spike_vec, spike_count, state_dbg
   );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath swept
// over N_NEURONS virtual neurons, one neuron per clock, started by tick.
module lif_scheduler #(
   parameter int N_NEURONS = 4,
   parameter int AW        = 2
) (
   input  logic           clk,
   input  logic           reset,
   lif_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_busy;
   logic                   w_done;
   logic                   w_accept;
   logic                   w_update;

   logic [AW-1:0]          r_idx;
   logic [4*N_NEURONS-1:0] r_cur;
   logic [3:0]             r_mem [N_NEURONS];
   logic [3:0]             r_th  [N_NEURONS];
   logic [2:0]             r_ref [N_NEURONS];
   logic [N_NEURONS-1:0]   r_spike_vec;
   logic [7:0]             r_spike_cnt;

   logic [3:0]             w_s;
   logic [3:0]             w_th;
   logic [2:0]             w_r;
   logic [3:0]             w_cur;
   logic [3:0]             w_leaked;
   logic [4:0]             w_sum;
   logic [3:0]             w_integ;
   logic                   w_fire;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_accept    = 1'b0;
      w_update    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.tick) begin
               w_accept    = 1'b1;
               w_state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_update = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_busy      = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Shared datapath: operands of the neuron selected by r_idx, all pre-update values.
   always_comb begin
      w_s      = r_mem[r_idx];
      w_th     = r_th[r_idx];
      w_r      = r_ref[r_idx];
      w_cur    = r_cur[{r_idx, 2'b00} +: 4];
      w_leaked = w_s >> bus.leak_shift;
      w_sum    = {1'b0, w_cur} + {1'b0, w_leaked};
      w_integ  = w_sum[4] ? 4'hF : w_sum[3:0];
      w_fire   = (w_r == 3'd0) && (w_s >= w_th);
   end

   // A threshold write in the same edge as that neuron's update lands after the compare.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_idx       <= '0;
         r_cur       <= '0;
         r_spike_vec <= '0;
         r_spike_cnt <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            r_mem[i] <= 4'd0;
            r_th[i]  <= 4'd8;
            r_ref[i] <= 3'd0;
         end
      end else begin
         if (bus.cfg_we) begin
            r_th[bus.cfg_addr] <= bus.cfg_threshold;
         end
         if (w_accept) begin
            r_cur       <= bus.current_in;
            r_spike_vec <= '0;
            r_idx       <= '0;
         end
         if (w_update) begin
            r_idx <= r_idx + 1'b1;
            if (w_r != 3'd0) begin
               r_ref[r_idx] <= w_r - 3'd1;
               r_mem[r_idx] <= 4'd0;
            end else if (w_fire) begin
               r_mem[r_idx]       <= 4'd0;
               r_ref[r_idx]       <= bus.refrac_cfg;
               r_spike_vec[r_idx] <= 1'b1;
               if (r_spike_cnt != 8'hFF) begin
                  r_spike_cnt <= r_spike_cnt + 8'd1;
               end
            end else begin
               r_mem[r_idx] <= w_integ;
            end
         end
      end
   end

   assign bus.rd_state    = r_mem[bus.rd_addr];
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.spike_vec   = r_spike_vec;
   assign bus.spike_count = r_spike_cnt;
   assign bus.state_dbg   = r_state;

endmodule
